// File: rtl/execute_multiply.sv
// -----------------------------------------------------------------------------
// execute_multiply
//
// Iterative 32x32 integer multiplier for the execute stage. It is the
// counterpart of execute_divide and uses the same enable/done handshake.
// Supported operations:
//   op 0 : mullw   low word of the signed product, with overflow flag
//   op 1 : mulhw   high word of the signed product
//   op 2 : mulhwu  high word of the unsigned product
//   op 3 : reserved, treated as mulhwu
//
// Signed operations multiply the operand magnitudes without sign. The sign is
// applied once, in FIX, by negating the 64-bit product.
//
// Parameters:
//   BITS_PER_CYCLE  multiplier bits retired per RUN cycle (1, 2, 4 or 8)
//
// Ports:
//   clk     in   1   clock, all state changes on posedge
//   reset   in   1   asynchronous, active-low reset
//   enable  in   1   request; held high until done is seen, then dropped
//   op      in   2   operation select (see above)
//   in_a    in   32  multiplicand, sampled only in IDLE when enable=1
//   in_b    in   32  multiplier, sampled only in IDLE when enable=1
//   done    out  1   result valid, high only in DONE
//   out     out  32  result word, valid while done=1
//   ov      out  1   mullw overflow, valid while done=1
//
// Optional feature macro:
//   EXECUTE_MULTIPLY_EARLY_OUT_EN  leave RUN as soon as the remaining
//   multiplier is zero. Results are unchanged; only latency shrinks.
// -----------------------------------------------------------------------------
module execute_multiply #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        done,
  output logic [31:0] out,
  output logic        ov
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = 32 / BPC;
  // One extra bit so the counter can run from N-1 down past zero. A set MSB
  // means every iteration has been retired.
  localparam int CW  = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic          neg_q;
  logic [31:0]   mcand_q;
  logic [31:0]   mplier_q;
  logic [63:0]   acc_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [31:0]   out_q;
  logic          ov_q;

  logic          signedOp_d;
  logic [31:0]   magA_d;
  logic [31:0]   magB_d;
  logic [CW-1:0] iterIdx_d;
  logic [5:0]    shiftAmt_d;
  logic [63:0]   partial_d;
  logic [63:0]   acc_d;
  logic [63:0]   prod_d;
  logic          runExit_d;

  // Magnitudes of the incoming operands. For signed ops, 0x80000000 negates to
  // itself, which is the correct unsigned magnitude.
  assign signedOp_d = (op == 2'd0) || (op == 2'd1);
  assign magA_d     = (signedOp_d && in_a[31]) ? (32'd0 - in_a) : in_a;
  assign magB_d     = (signedOp_d && in_b[31]) ? (32'd0 - in_b) : in_b;

  // The iteration index counts up while the counter counts down. It places
  // the partial product at the weight of the multiplier bits being retired.
  assign iterIdx_d  = CW'(N - 1) - cnt_q;
  assign shiftAmt_d = 6'(iterIdx_d) * 6'(BPC);
  assign partial_d  = ({32'd0, mcand_q} * {{(64 - BPC){1'b0}}, mplier_q[BPC-1:0]})
                      << shiftAmt_d;
  assign acc_d      = acc_q + partial_d;

  // Apply the sign only once, after the unsigned product is complete.
  assign prod_d     = neg_q ? (64'd0 - acc_q) : acc_q;

`ifdef EXECUTE_MULTIPLY_EARLY_OUT_EN
  // Once the remaining multiplier bits are zero, later iterations add only
  // zero, so the accumulator already holds the final product.
  assign runExit_d = cnt_q[CW-1] || (mplier_q == 32'd0);
`else
  assign runExit_d = cnt_q[CW-1];
`endif

  // Sequencer and datapath registers. An abort (enable low in RUN or FIX)
  // returns to IDLE without touching done/out/ov. IDLE reloads every working
  // register, so a stale partial product cannot leak into the next operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      neg_q    <= 1'b0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      out_q    <= 32'd0;
      ov_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            op_q     <= op;
            neg_q    <= signedOp_d && (in_a[31] ^ in_b[31]);
            mcand_q  <= magA_d;
            mplier_q <= magB_d;
            acc_q    <= 64'd0;
            cnt_q    <= CW'(N - 1);
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (runExit_d) begin
            state_q <= FIX;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> BPC;
            cnt_q    <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            out_q   <= (op_q == 2'd0) ? prod_d[31:0] : prod_d[63:32];
            ov_q    <= (op_q == 2'd0) && (prod_d[63:32] != {32{prod_d[31]}});
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!enable) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign out  = out_q;
  assign ov   = ov_q;

endmodule
